flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 16 bits and the flag vector at 3 bits, encoded as {Z,V,N}, with Z in bit 2, V in bit 1 and N in bit 0.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ex_valid  input  1  the EX-stage slot holds a live instruction.
REQ-005 ex_opcode  input  4  opcode of the EX-stage instruction.
REQ-006 alu_result  input  16  ALU output of the EX-stage instruction.
REQ-007 alu_ovfl  input  1  ALU overflow of the EX-stage instruction.
REQ-008 stall  input  1  the pipeline holds EX this cycle; the same instruction is presented again next cycle.
REQ-009 flush  input  1  squash the EX-stage instruction this cycle.
REQ-010 F  output  3  bypassed flags {Z,V,N} for the branch logic in ID.
REQ-011 F_reg  output  3  architected flag register contents.
REQ-012 flag_wr  output  3  registered per-bit write strobe, high for one cycle after a flag bit is committed.

Function
REQ-013 Update mask by opcode:
- 0x0 ADD and 0x1 SUB SHALL update Z, V and N.
- 0x2 XOR, 0x4 SLL, 0x5 SRA and 0x6 ROR SHALL update Z only.
- 0x3 RED, 0x7 PADDSB and 0x8-0xF SHALL update nothing.
REQ-014 Computed flags:
- Z = (alu_result == 16'h0000).
- N = alu_result[15].
- V = alu_ovfl.
REQ-015 Commit condition: commit = ex_valid & ~stall & ~flush.
REQ-016 When commit is high, each masked bit of F_reg SHALL take its computed value at the rising edge; unmasked bits SHALL hold.
REQ-017 When commit is low, F_reg SHALL hold all bits.
REQ-018 flag_wr SHALL equal (mask & {3{commit}}), registered, so it is visible the cycle after the edge at which F_reg changes.
REQ-019 Bypass: for each bit b, F[b] SHALL be the computed flag when ex_valid & ~flush & mask[b]; otherwise F[b] SHALL equal F_reg[b].
REQ-020 The bypass is combinational, with zero-cycle latency from EX inputs to F.
REQ-021 stall SHALL NOT suppress the bypass.
REQ-022 flush SHALL take priority over stall and ex_valid: no commit and no bypass.
REQ-023 Back-to-back flag-setting instructions SHALL each commit in their own commit cycle, with the later one overwriting the earlier one.
REQ-024 A stalled instruction SHALL commit exactly once, on its first non-stalled, non-flushed cycle.
REQ-025 Bits of alu_result and alu_ovfl not selected by the mask SHALL have no effect on F or F_reg.
REQ-026 The block SHALL contain no state other than F_reg and flag_wr.

Reset
REQ-027 While rst_n is low, F_reg and flag_wr SHALL be 3'b000 immediately, independent of clk.
REQ-028 While rst_n is low, F SHALL equal the bypass of EX inputs over F_reg = 3'b000.
REQ-029 Reset asserted mid-stall SHALL discard the pending commit.
REQ-030 The first commit after rst_n deasserts SHALL occur at the first rising edge that meets the commit condition.

Verification
REQ-031 Reset, then SUB with alu_result=16'h0000 and alu_ovfl=0, ex_valid=1 -> F=3'b100 in the same cycle; F_reg=3'b100 and flag_wr=3'b111 after the edge.
REQ-032 With F_reg=3'b011, XOR with alu_result=16'h8001 committed -> F_reg=3'b011 (only Z written, to 0); flag_wr=3'b100.
REQ-033 ADD with alu_result=16'h7FFF and alu_ovfl=1, held with stall=1 for 3 cycles -> F=3'b010 throughout; F_reg unchanged until the edge after stall drops, then 3'b010; flag_wr=3'b111 exactly once.
REQ-034 ADD with alu_result=16'h0000 and flush=1 -> F equals F_reg; no F_reg change; flag_wr=3'b000.
REQ-035 PADDSB and opcode 0xC with alu_result=16'h0000 -> F equals F_reg and F_reg is unchanged.
REQ-036 rst_n pulsed low asynchronously between edges with F_reg=3'b111 -> F_reg=3'b000 before the next edge.

Source files
------------

// File: rtl/flag_unit.sv
// Condition-flag unit: computes {Z,V,N} from the EX-stage ALU result, commits them
// to the architected flag register and bypasses them combinationally to the branch logic.
module flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        stall,
  input  logic        flush,
  output logic [2:0]  F,
  output logic [2:0]  F_reg,
  output logic [2:0]  flag_wr
);

  // Per-opcode update mask in {Z,V,N} order.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      4'h0, 4'h1:               m = 3'b111;
      4'h2, 4'h4, 4'h5, 4'h6:   m = 3'b100;
      default:                  m = 3'b000;
    endcase
    return m;
  endfunction

  // Merge new flag values into old ones under a bit mask.
  function automatic logic [2:0] flag_merge(input logic [2:0] old_v,
                                            input logic [2:0] new_v,
                                            input logic [2:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic [2:0] mask_s;
  logic [2:0] flags_s;
  logic [2:0] byp_mask_s;
  logic       commit_s;
  logic [2:0] f_reg_r;
  logic [2:0] flag_wr_r;

  // Decode, flag computation and commit/bypass qualification.
  always_comb begin
    mask_s     = flag_mask(ex_opcode);
    flags_s    = {(alu_result == 16'h0000), alu_ovfl, alu_result[15]};
    commit_s   = ex_valid & ~stall & ~flush;
    // stall deliberately does not gate the bypass; flush does
    byp_mask_s = mask_s & {3{ex_valid & ~flush}};
  end

  // Bypassed flags seen by the branch logic in ID.
  always_comb begin
    F = flag_merge(f_reg_r, flags_s, byp_mask_s);
  end

  // Architected flag register and one-cycle write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_reg_r   <= 3'b000;
      flag_wr_r <= 3'b000;
    end else begin
      if (commit_s) begin
        f_reg_r <= flag_merge(f_reg_r, flags_s, mask_s);
      end else begin
        f_reg_r <= f_reg_r;
      end
      flag_wr_r <= mask_s & {3{commit_s}};
    end
  end

  assign F_reg   = f_reg_r;
  assign flag_wr = flag_wr_r;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: per-cycle F checked in-cycle, committed
// F_reg/flag_wr expectations queued at drive time and popped after the edge.
module tb_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic [2:0]  F;
  logic [2:0]  F_reg;
  logic [2:0]  flag_wr;

  int n_checks;
  int n_fail;
  logic [2:0] m_freg;
  logic [5:0] exp_q[$];

  flag_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .stall      (stall),
    .flush      (flush),
    .F          (F),
    .F_reg      (F_reg),
    .flag_wr    (flag_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [2:0] model_mask(input logic [3:0] op);
    if (op == 4'h0 || op == 4'h1) return 3'b111;
    else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) return 3'b100;
    else return 3'b000;
  endfunction

  function automatic logic [2:0] model_flags(input logic [15:0] r, input logic o);
    logic [2:0] f;
    f[2] = (r == 16'h0000);
    f[1] = o;
    f[0] = r[15];
    return f;
  endfunction

  function automatic logic [2:0] model_f(input logic [2:0] freg);
    logic [2:0] m;
    logic [2:0] f;
    logic [2:0] res;
    m = model_mask(ex_opcode);
    f = model_flags(alu_result, alu_ovfl);
    res = freg;
    if (ex_valid && !flush) begin
      for (int b = 0; b < 3; b++) if (m[b]) res[b] = f[b];
    end
    return res;
  endfunction

  // One cycle: drive at posedge+1, check F in-cycle, queue post-edge expectations.
  task automatic step(input logic [3:0] op, input logic [15:0] res, input logic ovfl,
                      input logic v, input logic st, input logic fl);
    logic [2:0] m;
    logic [2:0] f;
    logic [2:0] nf;
    logic [2:0] wr;
    logic [5:0] e;
    logic       commit;
    ex_opcode = op; alu_result = res; alu_ovfl = ovfl;
    ex_valid = v; stall = st; flush = fl;
    #1;
    check_eq("F_bypass", F, model_f(m_freg));
    m = model_mask(op);
    f = model_flags(res, ovfl);
    commit = v && !st && !fl;
    nf = m_freg;
    wr = 3'b000;
    if (commit) begin
      for (int b = 0; b < 3; b++) if (m[b]) nf[b] = f[b];
      wr = m;
    end
    exp_q.push_back({nf, wr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("F_reg", F_reg, e[5:3]);
    check_eq("flag_wr", flag_wr, e[2:0]);
    m_freg = e[5:3];
  endtask

  task automatic idle();
    step(4'hF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse between edges; F_reg must clear before the next edge.
  task automatic async_reset_pulse();
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_opcode = 4'h0; alu_result = 16'h1234; alu_ovfl = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_F_reg", F_reg, 3'b000);
    check_eq("rst_flag_wr", flag_wr, 3'b000);
    m_freg = 3'b000;
    check_eq("rst_F", F, model_f(3'b000));
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_freg = 3'b000;
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_opcode = 4'h0; alu_result = 16'h0000; alu_ovfl = 1'b0;
    stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_F_reg", F_reg, 3'b000);
    check_eq("reset_flag_wr", flag_wr, 3'b000);
    check_eq("reset_F", F, 3'b100);
    ex_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_hold_F_reg", F_reg, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SUB zero result: F=100 in-cycle, F_reg=100 and flag_wr=111 after the edge
    step(4'h1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("sub_zero_F_reg", F_reg, 3'b100);
    check_eq("sub_zero_wr", flag_wr, 3'b111);

    // Reach F_reg=011, then XOR 8001 writes only Z
    step(4'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("add_011", F_reg, 3'b011);
    step(4'h2, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("xor_F_reg", F_reg, 3'b011);
    check_eq("xor_wr", flag_wr, 3'b100);

    // ADD 7FFF with overflow held by stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(4'h0, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("stall_hold", F_reg, 3'b011);
    end
    step(4'h0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("stall_commit", F_reg, 3'b010);
    check_eq("stall_wr", flag_wr, 3'b111);
    idle();
    check_eq("stall_wr_once", flag_wr, 3'b000);

    // Flushed ADD, flush beating stall, PADDSB and opcode 0xC
    step(4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    step(4'h0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'h7, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'hC, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'h3, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("no_update_F_reg", F_reg, 3'b010);

    // Back-to-back shifts/rotate then ADD overwrite
    step(4'h4, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'h5, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'h6, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'h0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Build F_reg=111 then async reset mid-cycle
    step(4'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'h2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pre_reset_111", F_reg, 3'b111);
    async_reset_pulse();
    idle();

    // Reset during a stalled ADD drops the pending commit
    step(4'h1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
    async_reset_pulse();
    idle();
    check_eq("stall_reset_discard", F_reg, 3'b000);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
           1'($urandom), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
